// File: rtl/sparc_window_ctrl.sv
// Register-window manager: owns CWP/WIM, executes SAVE/RESTORE, raises window
// overflow/underflow traps and sequences trap entry and RETT.
module sparc_window_ctrl #(
  parameter int unsigned NWIN  = 4,
  parameter int unsigned CWP_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Save,
  input  logic             Restore,
  input  logic             WrPsr,
  input  logic [CWP_W-1:0] PsrCwpIn,
  input  logic             WrWim,
  input  logic [NWIN-1:0]  WimIn,
  input  logic             TrapAck,
  input  logic             Rett,
  output logic [CWP_W-1:0] CWP,
  output logic [NWIN-1:0]  WIM,
  output logic             Trap,
  output logic [1:0]       TrapType,
  output logic             Busy,
  output logic             Done,
  output logic             Err
);

  typedef enum logic [1:0] {
    StIdle,
    StTrap,
    StHandler
  } state_e;

  localparam logic [1:0]      TtNone      = 2'b00;
  localparam logic [1:0]      TtOverflow  = 2'b01;
  localparam logic [1:0]      TtUnderflow = 2'b10;
  localparam logic [NWIN-1:0] WimRst      = NWIN'(2);

  state_e           state_q, state_d;
  logic [CWP_W-1:0] cwp_q, cwp_d;
  logic [NWIN-1:0]  wim_q, wim_d;
  logic             trap_q, trap_d;
  logic [1:0]       trap_type_q, trap_type_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [CWP_W-1:0] cwp_dec;
  logic [CWP_W-1:0] cwp_inc;
  logic             dec_invalid;
  logic             inc_invalid;

  // NWIN is a power of two, so natural CWP_W-bit wrap gives modulo-NWIN arithmetic.
  assign cwp_dec     = cwp_q - CWP_W'(1);
  assign cwp_inc     = cwp_q + CWP_W'(1);
  assign dec_invalid = wim_q[cwp_dec];
  assign inc_invalid = wim_q[cwp_inc];

  always_comb begin
    state_d     = state_q;
    cwp_d       = cwp_q;
    // WIM writes land in every state; a same-cycle SAVE/RESTORE checks wim_q.
    wim_d       = WrWim ? WimIn : wim_q;
    trap_d      = trap_q;
    trap_type_d = trap_type_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (WrPsr) begin
          cwp_d = PsrCwpIn;
          err_d = Save | Restore;
        end else if (Save && Restore) begin
          err_d = 1'b1;
        end else if (Save) begin
          if (dec_invalid) begin
            trap_d      = 1'b1;
            trap_type_d = TtOverflow;
            state_d     = StTrap;
          end else begin
            cwp_d  = cwp_dec;
            done_d = 1'b1;
          end
        end else if (Restore) begin
          if (inc_invalid) begin
            trap_d      = 1'b1;
            trap_type_d = TtUnderflow;
            state_d     = StTrap;
          end else begin
            cwp_d  = cwp_inc;
            done_d = 1'b1;
          end
        end
      end

      StTrap: begin
        if (TrapAck) begin
          cwp_d       = cwp_dec;
          trap_d      = 1'b0;
          trap_type_d = TtNone;
          state_d     = StHandler;
        end
      end

      StHandler: begin
        err_d = Save | Restore;
        if (Rett) begin
          cwp_d   = WrPsr ? PsrCwpIn : cwp_inc;
          state_d = StIdle;
        end else if (WrPsr) begin
          cwp_d = PsrCwpIn;
        end
      end

      default: begin
        state_d     = StIdle;
        trap_d      = 1'b0;
        trap_type_d = TtNone;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      cwp_q       <= '0;
      wim_q       <= WimRst;
      trap_q      <= 1'b0;
      trap_type_q <= TtNone;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cwp_q       <= cwp_d;
      wim_q       <= wim_d;
      trap_q      <= trap_d;
      trap_type_q <= trap_type_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign CWP      = cwp_q;
  assign WIM      = wim_q;
  assign Trap     = trap_q;
  assign TrapType = trap_type_q;
  assign Busy     = (state_q != StIdle);
  assign Done     = done_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_sparc_window_ctrl.sv
// Directed self-checking bench for sparc_window_ctrl; each task owns one scenario.
module tb_sparc_window_ctrl;

  logic       Clk;
  logic       Reset;
  logic       Save, Restore, WrPsr, WrWim, TrapAck, Rett;
  logic [1:0] PsrCwpIn;
  logic [3:0] WimIn;
  logic [1:0] CWP;
  logic [3:0] WIM;
  logic       Trap;
  logic [1:0] TrapType;
  logic       Busy, Done, Err;

  int nchecks = 0;
  int nerr    = 0;

  logic [11:0] obs;
  logic [11:0] e;
  assign obs = {CWP, WIM, Trap, TrapType, Busy, Done, Err};

  sparc_window_ctrl #(
    .NWIN (4),
    .CWP_W(2)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Save    (Save),
    .Restore (Restore),
    .WrPsr   (WrPsr),
    .PsrCwpIn(PsrCwpIn),
    .WrWim   (WrWim),
    .WimIn   (WimIn),
    .TrapAck (TrapAck),
    .Rett    (Rett),
    .CWP     (CWP),
    .WIM     (WIM),
    .Trap    (Trap),
    .TrapType(TrapType),
    .Busy    (Busy),
    .Done    (Done),
    .Err     (Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [11:0] ev(input logic [1:0] cwp, input logic [3:0] wim,
                                     input logic trap, input logic [1:0] tt,
                                     input logic busy, input logic done, input logic err);
    return {cwp, wim, trap, tt, busy, done, err};
  endfunction

  task automatic clr();
    Save = 0; Restore = 0; WrPsr = 0; WrWim = 0; TrapAck = 0; Rett = 0;
    PsrCwpIn = '0; WimIn = '0;
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge Clk);
    #1;
    clr();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clr();
    Reset = 1'b1;
    tick();
    e = ev(2'd0, 4'b0010, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL reset got %b exp %b", obs, e); end
    Reset = 1'b0;
    tick();
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL reset_rel got %b exp %b", obs, e); end
  endtask

  task automatic test_back_to_back_save();
    Save = 1; tick();
    e = ev(2'd3, 4'b0010, 0, 2'b00, 0, 1, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL save1 got %b exp %b", obs, e); end
    Save = 1; tick();
    e = ev(2'd2, 4'b0010, 0, 2'b00, 0, 1, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL save2 got %b exp %b", obs, e); end
    tick();
    e = ev(2'd2, 4'b0010, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL done_drop got %b exp %b", obs, e); end
  endtask

  task automatic test_overflow();
    Save = 1; tick();
    e = ev(2'd2, 4'b0010, 1, 2'b01, 1, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL ovf_trap got %b exp %b", obs, e); end
    // Requests during TRAP are ignored without Err.
    for (int i = 0; i < 3; i++) begin
      Save = (i == 0); WrPsr = (i == 1); PsrCwpIn = 2'd3; Rett = (i == 2);
      tick();
      nchecks++;
      if (obs !== e) begin nerr++; $display("FAIL ovf_hold%0d got %b exp %b", i, obs, e); end
    end
    TrapAck = 1; tick();
    e = ev(2'd1, 4'b0010, 0, 2'b00, 1, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL ovf_ack got %b exp %b", obs, e); end
    Save = 1; tick();
    e = ev(2'd1, 4'b0010, 0, 2'b00, 1, 0, 1);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL hdl_err got %b exp %b", obs, e); end
    Rett = 1; tick();
    e = ev(2'd2, 4'b0010, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL ovf_rett got %b exp %b", obs, e); end
  endtask

  task automatic test_underflow();
    do_reset();
    Restore = 1; tick();
    e = ev(2'd0, 4'b0010, 1, 2'b10, 1, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL unf_trap got %b exp %b", obs, e); end
    TrapAck = 1; tick();
    e = ev(2'd3, 4'b0010, 0, 2'b00, 1, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL unf_ack got %b exp %b", obs, e); end
    Rett = 1; tick();
    e = ev(2'd0, 4'b0010, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL unf_rett got %b exp %b", obs, e); end
  endtask

  task automatic test_wrap();
    WrWim = 1; WimIn = 4'b0000; tick();
    e = ev(2'd0, 4'b0000, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL wrwim got %b exp %b", obs, e); end
    WrPsr = 1; PsrCwpIn = 2'd0; tick();
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL wrpsr0 got %b exp %b", obs, e); end
    Save = 1; tick();
    e = ev(2'd3, 4'b0000, 0, 2'b00, 0, 1, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL wrap_save got %b exp %b", obs, e); end
    Restore = 1; tick();
    e = ev(2'd0, 4'b0000, 0, 2'b00, 0, 1, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL wrap_rest got %b exp %b", obs, e); end
    TrapAck = 1; Rett = 1; tick();
    e = ev(2'd0, 4'b0000, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL stray_ack got %b exp %b", obs, e); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    Save = 1; Restore = 1; tick();
    e = ev(2'd0, 4'b0010, 0, 2'b00, 0, 0, 1);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL sr_both got %b exp %b", obs, e); end
    WrPsr = 1; PsrCwpIn = 2'd2; Save = 1; tick();
    e = ev(2'd2, 4'b0010, 0, 2'b00, 0, 0, 1);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL psr_save got %b exp %b", obs, e); end
    Save = 1; WrWim = 1; WimIn = 4'b0000; tick();
    e = ev(2'd2, 4'b0000, 1, 2'b01, 1, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL old_wim got %b exp %b", obs, e); end
  endtask

  task automatic test_async_reset();
    // Still in TRAP with CWP=2 from the previous scenario.
    Reset = 1'b1;
    #1;
    e = ev(2'd0, 4'b0010, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL async_rst got %b exp %b", obs, e); end
    tick();
    Reset = 1'b0;
    tick();
    Save = 1; tick();
    e = ev(2'd3, 4'b0010, 0, 2'b00, 0, 1, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL post_rst got %b exp %b", obs, e); end
  endtask

  task automatic test_rett_wrpsr();
    WrPsr = 1; PsrCwpIn = 2'd0; tick();
    Restore = 1; tick();
    TrapAck = 1; tick();
    WrPsr = 1; PsrCwpIn = 2'd2; tick();
    e = ev(2'd2, 4'b0010, 0, 2'b00, 1, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL hdl_wrpsr got %b exp %b", obs, e); end
    Rett = 1; WrPsr = 1; PsrCwpIn = 2'd1; tick();
    e = ev(2'd1, 4'b0010, 0, 2'b00, 0, 0, 0);
    nchecks++; if (obs !== e) begin nerr++; $display("FAIL rett_psr got %b exp %b", obs, e); end
  endtask

  initial begin
    test_reset();
    test_back_to_back_save();
    test_overflow();
    test_underflow();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_rett_wrpsr();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
